conv_row_segmenter: RTL

- Parametrised successor of the convolution row-pixel indexer, sitting between the conv tiling loop and the input-row buffer address logic.
- For one output-x tile (ox_start, pox) it derives the input-x window, including kernel halo, stride and zero padding.
- It emits that window as a stream of row-buffer segments of at most PIXELS_IN_ROW pixels. Each segment carries row indices, register-slot indices and pad counts.
- Generalises the earlier block to any stride 1..S_MAX and any power-of-two segment width, and adds a valid/ready output handshake with backpressure.

---
 rtl/conv_row_segmenter.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_row_segmenter.sv
// conv_row_segmenter: derives the input-x window (halo, stride, zero padding)
// for one output-x tile and streams it as row-buffer segments of at most
// PIXELS_IN_ROW pixels over a valid/ready handshake.
// Optional feature macro: SEGMENT_ALIGN_EN -- when defined, every segment
// after the first starts on a multiple of PIXELS_IN_ROW in row coordinates.
module conv_row_segmenter #(
    parameter int PIXELS_IN_ROW = 32,
    parameter int IDX_W         = 16,
    parameter int PAD_W         = 4,
    parameter int S_MAX         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] ix,
    input  logic [IDX_W-1:0] ox_start,
    input  logic [IDX_W-1:0] pox,
    input  logic [PAD_W-1:0] k,
    input  logic [PAD_W-1:0] s,
    input  logic [PAD_W-1:0] p,
    output logic             seg_valid,
    input  logic             seg_ready,
    output logic [IDX_W-1:0] seg_row_start,
    output logic [IDX_W-1:0] seg_row_end,
    output logic [PAD_W-1:0] seg_west_pad,
    output logic [PAD_W-1:0] seg_east_pad,
    output logic [IDX_W-1:0] seg_reg_start,
    output logic [IDX_W-1:0] seg_reg_end,
    output logic             seg_first,
    output logic             seg_last,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int W = IDX_W + 2;
    typedef logic signed [W-1:0] sw_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_EMIT = 2'd2} state_t;

    localparam sw_t              ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam sw_t              ZERO     = {W{1'b0}};
    localparam sw_t              P_M1     = sw_t'(PIXELS_IN_ROW) - ONE;
    localparam logic [IDX_W-1:0] IDX1     = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX0     = {IDX_W{1'b0}};
    localparam logic [PAD_W-1:0] PAD0     = {PAD_W{1'b0}};
    localparam logic [PAD_W-1:0] S_MAX_P  = PAD_W'(S_MAX);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ix_q, ix_d, ox_start_q, ox_start_d, pox_q, pox_d;
    logic [PAD_W-1:0]   k_q, k_d, s_q, s_d, p_q, p_d;
    sw_t                row_last_q, row_last_d;
    logic [PAD_W-1:0]   right_pad_q, right_pad_d;
    logic               seg_valid_q, seg_valid_d;
    logic [IDX_W-1:0]   seg_start_q, seg_start_d;
    sw_t                seg_end_q, seg_end_d;
    logic [PAD_W-1:0]   seg_west_q, seg_west_d, seg_east_q, seg_east_d;
    logic [IDX_W-1:0]   seg_reg_start_q, seg_reg_start_d, seg_reg_end_q, seg_reg_end_d;
    logic               seg_first_q, seg_first_d, seg_last_q, seg_last_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;

    // window geometry (signed, two guard bits)
    sw_t  ix_v, ox_v, pox_v, k_v, s_v, p_v;
    sw_t  ix_start_c, ix_end_c, lp_raw_c, rp_raw_c, left_c, right_c;
    sw_t  row_first_c, row_last_c;
    logic stride_bad_c;

    // segment builder outputs
    logic             b_first, b_last;
    sw_t              b_start, b_row_last, b_cand, b_end, b_span;
    logic [PAD_W-1:0] b_right, b_east, b_west;
    logic [IDX_W-1:0] b_reg_start, b_reg_end;

    // Input-window geometry of the latched tile
    always_comb begin
        ix_v         = {{2{1'b0}}, ix_q};
        ox_v         = {{2{1'b0}}, ox_start_q};
        pox_v        = {{2{1'b0}}, pox_q};
        k_v          = {{(W-PAD_W){1'b0}}, k_q};
        s_v          = {{(W-PAD_W){1'b0}}, s_q};
        p_v          = {{(W-PAD_W){1'b0}}, p_q};
        ix_start_c   = (ox_v - ONE) * s_v + ONE;
        ix_end_c     = ix_start_c + (pox_v - ONE) * s_v + k_v - ONE;
        lp_raw_c     = p_v + ONE - ix_start_c;
        rp_raw_c     = ix_end_c - (p_v + ix_v);
        left_c       = (lp_raw_c > ZERO) ? lp_raw_c : ZERO;
        right_c      = (rp_raw_c > ZERO) ? rp_raw_c : ZERO;
        row_first_c  = ix_start_c + left_c - p_v - ONE;
        row_last_c   = ix_end_c - right_c - p_v - ONE;
        stride_bad_c = (s_q == PAD0) || (s_q > S_MAX_P);
    end

    // Fields of the segment to present next: the first one out of CALC,
    // the following one after a handshake in EMIT
    always_comb begin
        b_first     = (state_q == S_CALC);
        b_start     = b_first ? row_first_c : (seg_end_q + ONE);
        b_row_last  = b_first ? row_last_c : row_last_q;
        b_right     = b_first ? right_c[PAD_W-1:0] : right_pad_q;
        b_reg_start = b_first ? (left_c[IDX_W-1:0] + IDX1) : (seg_reg_end_q + IDX1);
`ifdef SEGMENT_ALIGN_EN
        b_cand      = b_start | P_M1;
`else
        b_cand      = b_start + P_M1;
`endif
        b_last      = (b_cand >= b_row_last);
        b_end       = b_last ? b_row_last : b_cand;
        b_east      = b_last ? b_right : PAD0;
        b_west      = b_first ? left_c[PAD_W-1:0] : PAD0;
        b_span      = b_end - b_start;
        b_reg_end   = b_reg_start + b_span[IDX_W-1:0] + {{(IDX_W-PAD_W){1'b0}}, b_east};
    end

    // Sequencing IDLE -> CALC -> EMIT and next values of every register
    always_comb begin
        state_d         = state_q;
        ix_d            = ix_q;
        ox_start_d      = ox_start_q;
        pox_d           = pox_q;
        k_d             = k_q;
        s_d             = s_q;
        p_d             = p_q;
        row_last_d      = row_last_q;
        right_pad_d     = right_pad_q;
        seg_valid_d     = seg_valid_q;
        seg_start_d     = seg_start_q;
        seg_end_d       = seg_end_q;
        seg_west_d      = seg_west_q;
        seg_east_d      = seg_east_q;
        seg_reg_start_d = seg_reg_start_q;
        seg_reg_end_d   = seg_reg_end_q;
        seg_first_d     = seg_first_q;
        seg_last_d      = seg_last_q;
        done_d          = 1'b0;
        err_d           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ix_d       = ix;
                    ox_start_d = ox_start;
                    pox_d      = pox;
                    k_d        = k;
                    s_d        = s;
                    p_d        = p;
                    state_d    = S_CALC;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_CALC: begin
                if (stride_bad_c) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (row_first_c > row_last_c) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d         = S_EMIT;
                    row_last_d      = row_last_c;
                    right_pad_d     = right_c[PAD_W-1:0];
                    seg_valid_d     = 1'b1;
                    seg_start_d     = b_start[IDX_W-1:0];
                    seg_end_d       = b_end;
                    seg_west_d      = b_west;
                    seg_east_d      = b_east;
                    seg_reg_start_d = b_reg_start;
                    seg_reg_end_d   = b_reg_end;
                    seg_first_d     = 1'b1;
                    seg_last_d      = b_last;
                end
            end
            S_EMIT: begin
                if (seg_ready && seg_last_q) begin
                    state_d         = S_IDLE;
                    done_d          = 1'b1;
                    seg_valid_d     = 1'b0;
                    seg_start_d     = IDX0;
                    seg_end_d       = ZERO;
                    seg_west_d      = PAD0;
                    seg_east_d      = PAD0;
                    seg_reg_start_d = IDX0;
                    seg_reg_end_d   = IDX0;
                    seg_first_d     = 1'b0;
                    seg_last_d      = 1'b0;
                end else if (seg_ready) begin
                    seg_start_d     = b_start[IDX_W-1:0];
                    seg_end_d       = b_end;
                    seg_west_d      = b_west;
                    seg_east_d      = b_east;
                    seg_reg_start_d = b_reg_start;
                    seg_reg_end_d   = b_reg_end;
                    seg_first_d     = 1'b0;
                    seg_last_d      = b_last;
                end else begin
                    state_d         = S_EMIT;
                end
            end
            default: begin
                state_d         = S_IDLE;
                seg_valid_d     = 1'b0;
                seg_start_d     = IDX0;
                seg_end_d       = ZERO;
                seg_west_d      = PAD0;
                seg_east_d      = PAD0;
                seg_reg_start_d = IDX0;
                seg_reg_end_d   = IDX0;
                seg_first_d     = 1'b0;
                seg_last_d      = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            ix_q            <= IDX0;
            ox_start_q      <= IDX0;
            pox_q           <= IDX0;
            k_q             <= PAD0;
            s_q             <= PAD0;
            p_q             <= PAD0;
            row_last_q      <= ZERO;
            right_pad_q     <= PAD0;
            seg_valid_q     <= 1'b0;
            seg_start_q     <= IDX0;
            seg_end_q       <= ZERO;
            seg_west_q      <= PAD0;
            seg_east_q      <= PAD0;
            seg_reg_start_q <= IDX0;
            seg_reg_end_q   <= IDX0;
            seg_first_q     <= 1'b0;
            seg_last_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            ix_q            <= ix_d;
            ox_start_q      <= ox_start_d;
            pox_q           <= pox_d;
            k_q             <= k_d;
            s_q             <= s_d;
            p_q             <= p_d;
            row_last_q      <= row_last_d;
            right_pad_q     <= right_pad_d;
            seg_valid_q     <= seg_valid_d;
            seg_start_q     <= seg_start_d;
            seg_end_q       <= seg_end_d;
            seg_west_q      <= seg_west_d;
            seg_east_q      <= seg_east_d;
            seg_reg_start_q <= seg_reg_start_d;
            seg_reg_end_q   <= seg_reg_end_d;
            seg_first_q     <= seg_first_d;
            seg_last_q      <= seg_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
        end
    end

    assign seg_valid     = seg_valid_q;
    assign seg_row_start = seg_start_q;
    assign seg_row_end   = seg_end_q[IDX_W-1:0];
    assign seg_west_pad  = seg_west_q;
    assign seg_east_pad  = seg_east_q;
    assign seg_reg_start = seg_reg_start_q;
    assign seg_reg_end   = seg_reg_end_q;
    assign seg_first     = seg_first_q;
    assign seg_last      = seg_last_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule
